// File: rtl/picosoc_iomem_display_if.sv
// PicoSoC iomem bus bundle: master issues requests, slave acknowledges with a one-cycle ready.
interface picosoc_iomem_display_if;
  logic        valid;
  logic        ready;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output valid, wstrb, addr, wdata, input ready, rdata);
  modport slave  (input valid, wstrb, addr, wdata, output ready, rdata);
endinterface

// File: rtl/picosoc_iomem_display.sv
// GPIO register on the iomem bus driving LEDs and a multiplexed 4-digit 7-segment display,
// plus a free-running colon blink and a status readback.
module picosoc_iomem_display #(
  parameter logic [23:0] TIMER_INIT   = 24'hF423FF,
  parameter logic [23:0] REFRESH_INIT = 24'h000F00,
  parameter logic [7:0]  GPIO_PAGE    = 8'h03,
  parameter logic [7:0]  TMPL_PAGE    = 8'h04
) (
  input  logic                     clk,
  input  logic                     resetn,
  picosoc_iomem_display_if.slave   bus,
  input  logic                     up_down,
  output logic [3:0]               dbg,
  output logic                     user_led,
  output logic [3:0]               comm,
  output logic                     colon,
  output logic [6:0]               seg
);

  logic [31:0] gpio_q, gpio_d;
  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic [23:0] sec_cnt_q, sec_cnt_d;
  logic [23:0] ref_cnt_q, ref_cnt_d;
  logic        toggle_q, toggle_d;
  logic [1:0]  dd_q, dd_d;
  logic        tick;
  logic        accept;
  logic [7:0]  page;
  logic [3:0]  nibble;
  logic        unused_addr;

  assign page        = bus.addr[31:24];
  assign unused_addr = ^bus.addr[23:0];
  // A request is only taken while ready is low, so a held valid is served every other cycle.
  assign accept      = bus.valid && !ready_q;

  always_comb begin
    ready_d = 1'b0;
    rdata_d = rdata_q;
    gpio_d  = gpio_q;
    if (accept && page == GPIO_PAGE) begin
      ready_d = 1'b1;
      rdata_d = {30'b0, up_down, toggle_q};
      for (int i = 0; i < 4; i++) begin
        if (bus.wstrb[i]) gpio_d[8*i +: 8] = bus.wdata[8*i +: 8];
      end
    end else if (accept && page == TMPL_PAGE) begin
      ready_d = 1'b1;
      rdata_d = '0;
    end
  end

  always_comb begin
    sec_cnt_d = sec_cnt_q - 24'd1;
    toggle_d  = toggle_q;
    if (sec_cnt_q == '0) begin
      sec_cnt_d = TIMER_INIT;
      toggle_d  = ~toggle_q;
    end
    tick      = (ref_cnt_q == '0);
    ref_cnt_d = tick ? REFRESH_INIT : ref_cnt_q - 24'd1;
    // Digits scan 3,2,1,0 and the 2-bit index wraps 0 back to 3.
    dd_d      = tick ? dd_q - 2'd1 : dd_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      gpio_q    <= '0;
      ready_q   <= 1'b0;
      rdata_q   <= '0;
      sec_cnt_q <= TIMER_INIT;
      ref_cnt_q <= REFRESH_INIT;
      toggle_q  <= 1'b1;
      dd_q      <= 2'd3;
    end else begin
      gpio_q    <= gpio_d;
      ready_q   <= ready_d;
      rdata_q   <= rdata_d;
      sec_cnt_q <= sec_cnt_d;
      ref_cnt_q <= ref_cnt_d;
      toggle_q  <= toggle_d;
      dd_q      <= dd_d;
    end
  end

  always_comb begin
    comm   = 4'b0111;
    nibble = gpio_q[3:0];
    unique case (dd_q)
      2'd0: begin comm = 4'b1110; nibble = gpio_q[15:12]; end
      2'd1: begin comm = 4'b1101; nibble = gpio_q[11:8];  end
      2'd2: begin comm = 4'b1011; nibble = gpio_q[7:4];   end
      2'd3: begin comm = 4'b0111; nibble = gpio_q[3:0];   end
      default: ;
    endcase
  end

  // Glyphs are drawn for an upside-down mounted display.
  always_comb begin
    seg = 7'h00;
    unique case (nibble)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h30;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h79;
      4'h4: seg = 7'h74;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h6F;
      4'h7: seg = 7'h38;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h7C;
      4'hA: seg = 7'h7E;
      4'hB: seg = 7'h67;
      4'hC: seg = 7'h0F;
      4'hD: seg = 7'h73;
      4'hE: seg = 7'h4F;
      4'hF: seg = 7'h4E;
      default: ;
    endcase
  end

  assign bus.ready = ready_q;
  assign bus.rdata = rdata_q;
  assign dbg       = gpio_q[3:0];
  assign user_led  = gpio_q[4];
  assign colon     = toggle_q;

endmodule

// File: tb/tb_picosoc_iomem_display.sv
// Randomized bench for picosoc_iomem_display against a cycle-count based reference model.
module tb_picosoc_iomem_display;
  localparam logic [23:0] T_INIT = 24'd299;
  localparam logic [23:0] R_INIT = 24'd15;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       up_down = 1'b0;
  logic [3:0] dbg, comm;
  logic       user_led, colon;
  logic [6:0] seg;

  int checks = 0;
  int failures = 0;
  int cyc;
  logic [31:0] m_gpio = '0;
  logic [6:0] seg_tab [16] = '{7'h3F, 7'h30, 7'h5B, 7'h79, 7'h74, 7'h6D, 7'h6F, 7'h38,
                               7'h7F, 7'h7C, 7'h7E, 7'h67, 7'h0F, 7'h73, 7'h4F, 7'h4E};

  picosoc_iomem_display_if bus ();

  picosoc_iomem_display #(
    .TIMER_INIT  (T_INIT),
    .REFRESH_INIT(R_INIT),
    .GPIO_PAGE   (8'h03),
    .TMPL_PAGE   (8'h04)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .bus     (bus),
    .up_down (up_down),
    .dbg     (dbg),
    .user_led(user_led),
    .comm    (comm),
    .colon   (colon),
    .seg     (seg)
  );

  always #5 clk = ~clk;

  // Number of clock edges since reset release; the model derives everything from this.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  function automatic logic m_colon(input int n);
    return ((n / (int'(T_INIT) + 1)) % 2) == 0;
  endfunction

  function automatic int m_dd(input int n);
    return 3 - ((n / (int'(R_INIT) + 1)) % 4);
  endfunction

  function automatic logic [3:0] m_comm(input int d);
    return ~(4'b0001 << d);
  endfunction

  function automatic logic [6:0] m_seg(input int d);
    logic [31:0] sh;
    sh = m_gpio >> ((3 - d) * 4);
    return seg_tab[sh[3:0]];
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] ws);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (ws[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  // One-cycle request; reports ready at the first edge, ready at the second, and the rdata,
  // plus the expected status word captured from the model in the accept cycle.
  task automatic xfer(input logic [31:0] addr, input logic [3:0] ws, input logic [31:0] wd,
                      output logic rdy1, output logic rdy2, output logic [31:0] rd,
                      output logic [31:0] exp_status);
    @(negedge clk);
    bus.valid = 1'b1;
    bus.addr  = addr;
    bus.wstrb = ws;
    bus.wdata = wd;
    exp_status = {30'b0, up_down, m_colon(cyc)};
    @(posedge clk);
    #1;
    rdy1 = bus.ready;
    rd   = bus.rdata;
    bus.valid = 1'b0;
    @(posedge clk);
    #1;
    rdy2 = bus.ready;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({dbg, user_led, colon, comm, seg, bus.ready, bus.rdata} !==
        {4'h0, 1'b0, 1'b1, 4'b0111, 7'h3F, 1'b0, 32'h0}) begin
      failures++;
      $display("FAIL reset_state: got dbg=%h led=%b colon=%b comm=%b seg=%h rdy=%b rd=%h",
               dbg, user_led, colon, comm, seg, bus.ready, bus.rdata);
    end
    @(negedge clk);
    resetn = 1'b1;
    m_gpio = '0;
  endtask

  task automatic test_read;
    logic r1, r2;
    logic [31:0] rd, st;
    up_down = 1'b1;
    xfer(32'h0300_0000, 4'h0, 32'h0, r1, r2, rd, st);
    checks++;
    if (r1 !== 1'b1 || rd !== 32'h3 || st !== 32'h3) begin
      failures++;
      $display("FAIL read_status_on: got rdy=%b rdata=%h expected rdy=1 rdata=%h", r1, rd, st);
    end
    for (int i = 0; i < int'(T_INIT) + 10 && m_colon(cyc); i++) begin
      @(negedge clk);
      checks++;
      if (colon !== m_colon(cyc)) begin
        failures++;
        $display("FAIL colon_track: got %b expected %b at cycle %0d", colon, m_colon(cyc), cyc);
      end
    end
    checks++;
    if (colon !== 1'b0) begin
      failures++;
      $display("FAIL colon_toggle: got %b expected 0", colon);
    end
    xfer(32'h0300_0000, 4'h0, 32'h0, r1, r2, rd, st);
    checks++;
    if (rd !== 32'h2 || st !== 32'h2) begin
      failures++;
      $display("FAIL read_status_off: got %h expected %h (ref 2)", rd, st);
    end
  endtask

  task automatic test_write_display;
    logic r1, r2;
    logic [31:0] rd, st;
    xfer(32'h0300_0000, 4'hF, 32'h0000_1234, r1, r2, rd, st);
    m_gpio = 32'h0000_1234;
    checks++;
    if (r1 !== 1'b1 || r2 !== 1'b0) begin
      failures++;
      $display("FAIL write_ready_pulse: got %b%b expected 10", r1, r2);
    end
    for (int i = 0; i < 4 * (int'(R_INIT) + 1) + 8; i++) begin
      @(negedge clk);
      checks++;
      if (comm !== m_comm(m_dd(cyc)) || seg !== m_seg(m_dd(cyc))) begin
        failures++;
        $display("FAIL scan: got comm=%b seg=%h expected comm=%b seg=%h at cycle %0d",
                 comm, seg, m_comm(m_dd(cyc)), m_seg(m_dd(cyc)), cyc);
      end
    end
  endtask

  task automatic test_byte_write;
    logic r1, r2;
    logic [31:0] rd, st, a, wd;
    logic [3:0] ws;
    logic [7:0] pg;
    xfer(32'h0300_0000, 4'h1, 32'h0000_00AB, r1, r2, rd, st);
    m_gpio = merge(m_gpio, 32'h0000_00AB, 4'h1);
    checks++;
    if (m_gpio !== 32'h0000_12AB || dbg !== 4'hB || user_led !== 1'b0) begin
      failures++;
      $display("FAIL byte_write: got dbg=%h led=%b expected dbg=b led=0", dbg, user_led);
    end
    for (int k = 0; k < 24; k++) begin
      pg = 8'h03 + 8'($urandom_range(0, 2));
      a  = {pg, 24'($urandom)};
      ws = 4'($urandom);
      wd = $urandom;
      up_down = 1'($urandom);
      xfer(a, ws, wd, r1, r2, rd, st);
      if (pg == 8'h03) m_gpio = merge(m_gpio, wd, ws);
      checks++;
      if (r1 !== (pg != 8'h05) || r2 !== 1'b0) begin
        failures++;
        $display("FAIL rand_ready: page %h got %b%b", pg, r1, r2);
      end
      if (pg != 8'h05) begin
        checks++;
        if (rd !== ((pg == 8'h03) ? st : 32'h0)) begin
          failures++;
          $display("FAIL rand_rdata: page %h got %h expected %h", pg, rd,
                   (pg == 8'h03) ? st : 32'h0);
        end
      end
      @(negedge clk);
      checks++;
      if (dbg !== m_gpio[3:0] || user_led !== m_gpio[4] ||
          comm !== m_comm(m_dd(cyc)) || seg !== m_seg(m_dd(cyc))) begin
        failures++;
        $display("FAIL rand_outputs: got dbg=%h led=%b comm=%b seg=%h expected %h %b %b %h",
                 dbg, user_led, comm, seg, m_gpio[3:0], m_gpio[4], m_comm(m_dd(cyc)),
                 m_seg(m_dd(cyc)));
      end
    end
  endtask

  task automatic test_tmpl_and_unmapped;
    logic r1, r2;
    logic [31:0] rd, st;
    xfer(32'h0400_0010, 4'hF, $urandom, r1, r2, rd, st);
    checks++;
    if (r1 !== 1'b1 || r2 !== 1'b0 || rd !== 32'h0) begin
      failures++;
      $display("FAIL tmpl_access: got rdy=%b%b rdata=%h expected 10 0", r1, r2, rd);
    end
    @(negedge clk);
    bus.valid = 1'b1;
    bus.addr  = 32'h0500_0000;
    bus.wstrb = 4'hF;
    bus.wdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.ready !== 1'b0) begin
        failures++;
        $display("FAIL unmapped_ready: got %b expected 0 on cycle %0d", bus.ready, i);
      end
    end
    bus.valid = 1'b0;
    @(negedge clk);
    checks++;
    if (dbg !== m_gpio[3:0] || seg !== m_seg(m_dd(cyc))) begin
      failures++;
      $display("FAIL unmapped_nowrite: got dbg=%h seg=%h expected %h %h",
               dbg, seg, m_gpio[3:0], m_seg(m_dd(cyc)));
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] wd;
    logic [5:0] seen;
    wd = $urandom;
    @(negedge clk);
    bus.valid = 1'b1;
    bus.addr  = 32'h0300_0000;
    bus.wstrb = 4'hF;
    bus.wdata = wd;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      seen[5 - i] = bus.ready;
    end
    bus.valid = 1'b0;
    m_gpio = wd;
    checks++;
    if (seen !== 6'b101010) begin
      failures++;
      $display("FAIL held_valid: got %b expected 101010", seen);
    end
    @(negedge clk);
    checks++;
    if (dbg !== m_gpio[3:0] || seg !== m_seg(m_dd(cyc))) begin
      failures++;
      $display("FAIL held_write: got dbg=%h seg=%h expected %h %h",
               dbg, seg, m_gpio[3:0], m_seg(m_dd(cyc)));
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    bus.valid = 1'b1;
    bus.addr  = 32'h0300_0000;
    bus.wstrb = 4'hF;
    bus.wdata = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    checks++;
    if (bus.ready !== 1'b1 || dbg !== 4'hF) begin
      failures++;
      $display("FAIL mid_accept: got rdy=%b dbg=%h expected 1 f", bus.ready, dbg);
    end
    #1;
    resetn = 1'b0;
    #1;
    checks++;
    if ({bus.ready, dbg, user_led, colon, comm, seg, bus.rdata} !==
        {1'b0, 4'h0, 1'b0, 1'b1, 4'b0111, 7'h3F, 32'h0}) begin
      failures++;
      $display("FAIL mid_reset: got rdy=%b dbg=%h led=%b colon=%b comm=%b seg=%h rd=%h",
               bus.ready, dbg, user_led, colon, comm, seg, bus.rdata);
    end
    bus.valid = 1'b0;
    m_gpio = '0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    bus.valid = 1'b0;
    bus.addr  = '0;
    bus.wstrb = '0;
    bus.wdata = '0;
    test_reset();
    test_read();
    test_write_display();
    test_byte_write();
    test_tmpl_and_unmapped();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
